imem_resp: RTL

IMEM_RESP -- requirements
Module: imem_resp

---
 rtl/imem_resp.sv | 135 +++++++++++++
 1 files changed

// File: rtl/imem_resp.sv
// Instruction memory with a fixed-latency response path: the word is read when the
// request is accepted, delayed LATENCY cycles, then held in a 2-entry in-order FIFO.
module imem_resp #(
    parameter int LATENCY   = 2,
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    output logic        req_ready,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_inst,
    output logic [63:0] resp_addr,
    output logic        resp_fault,
    input  logic        load_en,
    input  logic [9:0]  load_addr,
    input  logic [31:0] load_data
);

    localparam logic [31:0] NOP = 32'hD503201F;

    logic [31:0] mem [MEM_WORDS];

    logic               accept;
    logic               fault_in;
    logic [31:0]        inst_in;
    logic               push;
    logic               pop;

    logic [LATENCY-1:0] pv;
    logic [LATENCY-1:0] pfault;
    logic [31:0]        pinst [LATENCY];
    logic [63:0]        paddr [LATENCY];

    logic [31:0]        finst [2];
    logic [63:0]        faddr [2];
    logic [1:0]         ffault;
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         fcnt;

    logic [2:0]         inflight;
    logic [2:0]         outstanding;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + 3'(pv[i]);
        end
    end

    // Capping outstanding work at two guarantees the FIFO can never overflow.
    assign outstanding = inflight + {1'b0, fcnt};
    assign req_ready   = flush || (outstanding < 3'd2);
    assign accept      = req_valid && req_ready;

    assign fault_in = (req_addr[1:0] != 2'b00) || (req_addr[63:12] != '0);
    assign inst_in  = fault_in ? NOP : mem[req_addr[11:2]];

    assign resp_valid = (fcnt != 2'd0) && !flush;
    assign push       = pv[LATENCY-1] && !flush;
    assign pop        = resp_valid && resp_ready;

    assign resp_inst  = resp_valid ? finst[rd_ptr]  : '0;
    assign resp_addr  = resp_valid ? faddr[rd_ptr]  : '0;
    assign resp_fault = resp_valid ? ffault[rd_ptr] : 1'b0;

    // Contents survive reset; a same-edge read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv     <= '0;
            pfault <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pinst[i] <= '0;
                paddr[i] <= '0;
            end
        end else begin
            // Stage 0 takes the new request even on flush: it is the redirect target.
            pv[0] <= accept;
            if (accept) begin
                pinst[0]  <= inst_in;
                paddr[0]  <= req_addr;
                pfault[0] <= fault_in;
            end
            for (int i = 1; i < LATENCY; i++) begin
                pv[i]     <= pv[i-1] && !flush;
                pinst[i]  <= pinst[i-1];
                paddr[i]  <= paddr[i-1];
                pfault[i] <= pfault[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            ffault <= '0;
            for (int i = 0; i < 2; i++) begin
                finst[i] <= '0;
                faddr[i] <= '0;
            end
        end else if (flush) begin
            fcnt   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                finst[wr_ptr]  <= pinst[LATENCY-1];
                faddr[wr_ptr]  <= paddr[LATENCY-1];
                ffault[wr_ptr] <= pfault[LATENCY-1];
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fcnt <= fcnt + 2'd1;
                2'b01:   fcnt <= fcnt - 2'd1;
                default: fcnt <= fcnt;
            endcase
        end
    end

endmodule
